// File: rtl/ipf_pkg.sv
// ipf_pkg: shared encodings, per-mode schedule constants, FSM state enum and
// the per-word tag bundle for the IPF feeder.
package ipf_pkg;

    typedef enum logic [1:0] {
        CTRL_END   = 2'd0,
        CTRL_START = 2'd1,
        CTRL_HOLD  = 2'd2
    } ipf_ctrl_e;

    localparam logic [1:0] WS_3X3 = 2'd0;
    localparam logic [1:0] WS_5X5 = 2'd1;

    localparam int WN_3X3  = 18;
    localparam int WN_5X5  = 25;
    localparam int PRE_3X3 = 2;
    localparam int PRE_5X5 = 4;
    localparam int ROWS    = 8;

    // Shared word/row counter width; must hold WN_5X5 - 1.
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_PRE,
        ST_MAIN,
        ST_TAIL,
        ST_ENDW
    } ipf_state_e;

    typedef struct packed {
        logic [3:0] wgroup;
        logic [2:0] wround;
    } ipf_tag_t;

    function automatic logic [CNT_W-1:0] wn_of(input logic [1:0] ws);
        return (ws == WS_5X5) ? CNT_W'(WN_5X5) : CNT_W'(WN_3X3);
    endfunction

    function automatic logic [CNT_W-1:0] pre_of(input logic [1:0] ws);
        return (ws == WS_5X5) ? CNT_W'(PRE_5X5) : CNT_W'(PRE_3X3);
    endfunction

endpackage

// File: rtl/ipf_feed_align.sv
// ipf_feed_align: one-cycle stage lining up valid/ctrl/tags with the
// synchronous-read buffer data, which arrives one cycle after the request.
// Ports:
//   clk, rst              clock, async active-high reset
//   w_rd_en, i_rd_en      read requests issued this cycle
//   ctrl_d, tag_d         ctrl code and tags belonging to those requests
//   w_rd_data, i_rd_data  buffer read data (valid the cycle after the request)
//   w_valid/w_data, i_valid/i_data  aligned streams to IPF (data held when idle)
//   ctrl, tag             aligned ctrl code and wgroup/wround
module ipf_feed_align
    import ipf_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_rd_en,
    input  logic              i_rd_en,
    input  logic [1:0]        ctrl_d,
    input  ipf_tag_t          tag_d,
    input  logic [DATA_W-1:0] w_rd_data,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              w_valid,
    output logic              i_valid,
    output logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] i_data,
    output logic [1:0]        ctrl,
    output ipf_tag_t          tag
);

    logic [DATA_W-1:0] w_hold, i_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_valid <= 1'b0;
            i_valid <= 1'b0;
            ctrl    <= CTRL_HOLD;
            tag     <= '0;
            w_hold  <= '0;
            i_hold  <= '0;
        end else begin
            w_valid <= w_rd_en;
            i_valid <= i_rd_en;
            ctrl    <= ctrl_d;
            // Tags only move with a real word so they stay stable in gaps.
            if (w_rd_en || i_rd_en) tag <= tag_d;
            if (w_valid) w_hold <= w_rd_data;
            if (i_valid) i_hold <= i_rd_data;
        end
    end

    // Buffer data is passed straight through on its valid cycle; the hold
    // registers keep the last word visible afterwards.
    assign w_data = w_valid ? w_rd_data : w_hold;
    assign i_data = i_valid ? i_rd_data : i_hold;

endmodule

// File: rtl/ipf_feeder.sv
// ipf_feeder: replays the per-mode weight/input schedule from the local
// buffers into IPF, tags each word with ctrl/wgroup/wround, then holds END
// until IPF reports finish.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, cfg_wsize, cfg_npass  run request and configuration (IDLE only)
//   w_rd_en/w_rd_addr/w_rd_data  weight buffer read port
//   i_rd_en/i_rd_addr/i_rd_data  input buffer read port
//   w_valid/w_data, i_valid/i_data  streams to IPF
//   ctrl, Wsize, wgroup, wround  IPF control and tags
//   finish                   completion from IPF
//   busy, done, cfg_err      status
module ipf_feeder
    import ipf_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int W_ADDR_W = 5,
    parameter int I_ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          cfg_wsize,
    input  logic [3:0]          cfg_npass,
    output logic                w_rd_en,
    output logic [W_ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_W-1:0]   w_rd_data,
    output logic                i_rd_en,
    output logic [I_ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0]   i_rd_data,
    output logic                w_valid,
    output logic [DATA_W-1:0]   w_data,
    output logic                i_valid,
    output logic [DATA_W-1:0]   i_data,
    output logic [1:0]          ctrl,
    output logic [1:0]          Wsize,
    output logic [3:0]          wgroup,
    output logic [2:0]          wround,
    input  logic                finish,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    ipf_state_e       state, nstate;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       p;
    logic [3:0]       npass_q;
    logic [1:0]       ws_q;
    logic [CNT_W-1:0] wn, pre;
    logic             cfg_ok, tail_need, last_pass, row_last, pass_end;
    logic [1:0]       ctrl_d;
    ipf_tag_t         tag_d, tag_q;

    assign cfg_ok    = (cfg_wsize == WS_3X3) || (cfg_wsize == WS_5X5);
    assign wn        = wn_of(ws_q);
    assign pre       = pre_of(ws_q);
    // 5x5 needs the extra 8-row tail only to prime the window on pass 0.
    assign tail_need = (ws_q == WS_3X3) || (p == 4'd0);
    assign last_pass = ({1'b0, p} + 5'd1) >= {1'b0, npass_q};
    assign row_last  = (cnt == CNT_W'(ROWS - 1));
    assign pass_end  = row_last && ((state == ST_TAIL) ||
                                    (state == ST_MAIN && !tail_need));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:  if (start && cfg_ok) nstate = ST_WLOAD;
            ST_WLOAD: if (cnt == wn - 1'b1) nstate = ST_PRE;
            ST_PRE:   if (cnt == pre - 1'b1) nstate = ST_MAIN;
            ST_MAIN:  if (row_last) nstate = tail_need ? ST_TAIL :
                                             (last_pass ? ST_ENDW : ST_PRE);
            ST_TAIL:  if (row_last) nstate = last_pass ? ST_ENDW : ST_PRE;
            ST_ENDW:  if (finish) nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    // Output logic: read requests and the ctrl code for the word they fetch
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        i_rd_en   = 1'b0;
        i_rd_addr = '0;
        ctrl_d    = CTRL_HOLD;
        case (state)
            ST_WLOAD: begin
                w_rd_en   = 1'b1;
                w_rd_addr = W_ADDR_W'(cnt);
            end
            ST_PRE: begin
                i_rd_en   = 1'b1;
                i_rd_addr = I_ADDR_W'(cnt);
            end
            ST_MAIN, ST_TAIL: begin
                i_rd_en   = 1'b1;
                i_rd_addr = I_ADDR_W'(cnt);
                ctrl_d    = CTRL_START;
            end
            ST_ENDW: ctrl_d = CTRL_END;
            default: ;
        endcase
    end

    always_comb begin
        tag_d = '0;
        if (ws_q == WS_3X3) tag_d.wgroup = p;
        else                tag_d.wround = {2'b00, p[0]};
    end

    // Configuration, counters and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_q    <= '0;
            npass_q <= '0;
            p       <= '0;
            cnt     <= '0;
            cfg_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            done    <= (state == ST_ENDW) && finish;
            if (state == ST_IDLE && start) begin
                if (cfg_ok) begin
                    ws_q    <= cfg_wsize;
                    npass_q <= (cfg_npass == 4'd0) ? 4'd1 : cfg_npass;
                    p       <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (pass_end) p <= p + 4'd1;
            // MAIN resumes at the row right after the preload window.
            if (nstate != state)
                cnt <= (nstate == ST_MAIN) ? pre : '0;
            else if (state inside {ST_WLOAD, ST_PRE, ST_MAIN, ST_TAIL})
                cnt <= cnt + 1'b1;
        end
    end

    ipf_feed_align #(.DATA_W(DATA_W)) u_align (
        .clk       (clk),
        .rst       (rst),
        .w_rd_en   (w_rd_en),
        .i_rd_en   (i_rd_en),
        .ctrl_d    (ctrl_d),
        .tag_d     (tag_d),
        .w_rd_data (w_rd_data),
        .i_rd_data (i_rd_data),
        .w_valid   (w_valid),
        .i_valid   (i_valid),
        .w_data    (w_data),
        .i_data    (i_data),
        .ctrl      (ctrl),
        .tag       (tag_q)
    );

    assign wgroup = tag_q.wgroup;
    assign wround = tag_q.wround;
    assign Wsize  = ws_q;
    assign busy   = (state != ST_IDLE);

endmodule
